external_io_chain: RTL and testbench
====================================

Name: external_io_chain

Overview:
- Parametrised successor to the top-level host IO block for the shapool miner.
- Accepts job and device configuration over two SPI-like shift ports and controls the shapool run.
- Captures a result frame carrying a valid flag, and shifts it out through a daisy chain of devices.
- Neighbour devices are linked with ready_in/ready_out, so one success anywhere stops the whole chain.

Parameters:
JOB_CONFIG_WIDTH, 352, bits in job_config shift register (>=2)
DEVICE_CONFIG_WIDTH, 8, bits in device_config shift register (>=2)
RESULT_DATA_WIDTH, 32, bits of shapool_result (>=1); result frame is RESULT_DATA_WIDTH+1 bits
SYNC_STAGES, 2, synchroniser flops on every async input (2..4)

Ports:
clk  input  1  core clock
reset_n  input  1  asynchronous, active-low reset
sck0  input  1  job port serial clock (async)
sdi0  input  1  job port serial data (async)
cs0_n  input  1  job port select, active low (async)
sck1  input  1  chain port serial clock (async)
sdi1  input  1  chain port serial data in (async)
sdo1  output  1  chain port serial data out
cs1_n  input  1  chain port select, active low (async)
start  input  1  host run request, level (async)
ready_in  input  1  upstream neighbour done (async)
ready_out  output  1  this device or upstream done
shapool_run  output  1  enables shapool core
job_config  output  JOB_CONFIG_WIDTH  stored job
device_config  output  DEVICE_CONFIG_WIDTH  stored device config
shapool_result  input  RESULT_DATA_WIDTH  nonce from shapool
shapool_success  input  1  one-cycle success pulse, clk domain

Behaviour:
- Reset (async assert, sync release): state=LOAD; sdo1=0; ready_out=0; shapool_run=0; job_config=0; device_config=0; frame=0; all synchronisers=0.
- Synchronisation:
  - sck*, sdi*, cs*_n, start and ready_in each pass through SYNC_STAGES flops.
  - Edges are taken from the last two sck stages.
  - sdi and cs are sampled from the stage aligned with the edge's newer sample, so data and clock have equal latency.
- LOAD:
  - cs0_n low and sck0 rising: job_config <= {job_config[W-2:0], sdi0}, msb-first.
  - cs1_n low and sck1 rising: device_config shifts sdi1 in, msb-first.
  - cs1_n low and sck1 falling: sdo1 <= device_config msb (chain passthrough of config).
  - Both ports may shift on the same clk independently.
  - Synchronised start rising, with both cs high: go to EXEC, shapool_run=1 from the next cycle.
  - start rising while either cs is low is ignored; it must be re-raised.
- EXEC, in priority order:
  - shapool_success: frame <= {1'b1, shapool_result}; sdo1 <= 1; go to DONE.
  - Synchronised ready_in high: frame <= 0; sdo1 <= 0; go to DONE.
  - cs1_n low (host abort): same as ready_in.
  - Config registers are frozen in EXEC and DONE.
- DONE:
  - shapool_run=0 from the first DONE cycle, i.e. the success cycle plus 1.
  - ready_out=1.
  - cs1_n low and sck1 rising: frame <= {frame[RESULT_DATA_WIDTH-1:0], sdi1}.
  - cs1_n low and sck1 falling: sdo1 <= frame msb.
  - Synchronised start low with cs1_n high: go to LOAD; ready_out=0; frame retained.
- ready_out = (state==DONE) | sync ready_in, registered with 1-cycle latency. It therefore propagates one device per SYNC_STAGES+1 cycles.
- Simultaneous success and ready_in in the same cycle: success wins (valid result kept).
- Simultaneous sck rising and falling edge cannot occur on one line. A rising edge on one port plus a falling edge on the other is legal.
- Reset mid-shift discards partial data; configs return to 0.
- An undefined state encoding goes to LOAD with all outputs at reset values.
- The host clocks N*(RESULT_DATA_WIDTH+1) bits for an N-device chain. The device nearest the host outputs first.

Decomposition:
- Shared package external_io_pkg holds:
  - state encoding localparams STATE_LOAD=2'b00, STATE_EXEC=2'b01, STATE_DONE=2'b10;
  - the frame-width function RESULT_DATA_WIDTH+1.
- One sub-module, io_sync_edge: parametrised SYNC_STAGES synchroniser with rise/fall strobes and a delayed data tap. It is instanced per sck/sdi/cs pair, plus once each for start and ready_in.

Test Plan:
- Job load: with cs0_n low, shift 352 bits of pattern 0xA5 repeating -> job_config equals the pattern, device_config unchanged at 0.
- Run and success: start high, then shapool_success pulse with result 0x12345678 -> shapool_run falls 1 cycle later; ready_out=1 one cycle later; 33 sck1 cycles give sdo1 stream 1, then 0x12345678 msb-first.
- Neighbour stop: in EXEC raise ready_in -> DONE after SYNC_STAGES+1 cycles; frame shifts out 33 zeros; ready_out=1.
- Priority: shapool_success and synchronised ready_in on the same clk -> frame valid bit=1 with the captured result.
- Two-device chain (sdo1 of A to sdi1 of B): A succeeds with 0xDEADBEEF, B stopped via ready_in -> 66 clocks from B yield B's frame (zeros) then A's frame {1,0xDEADBEEF}.
- Reset mid-shift: pull reset_n low after 100 job bits -> job_config=0, state=LOAD, sdo1=0 immediately (asynchronous).

Source files
------------

// File: rtl/external_io_pkg.sv
// Shared definitions for the external IO chain: FSM encoding and frame sizing.
package external_io_pkg;

  typedef enum logic [1:0] {
    STATE_LOAD = 2'b00,
    STATE_EXEC = 2'b01,
    STATE_DONE = 2'b10
  } state_e;

  // A result frame is the valid flag followed by the nonce.
  function automatic int frame_width(input int result_data_width);
    return result_data_width + 1;
  endfunction

endpackage

// File: rtl/io_sync_edge.sv
// Multi-stage synchroniser for one async line with rise/fall strobes, plus a
// data tap delayed to the same latency as the edge strobes.
module io_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_WIDTH  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  line_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  level_o,
  output logic                  rise_o,
  output logic                  fall_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  // line_q[0] is the newest sample; edges compare the last two stages.
  logic [SYNC_STAGES-1:0] line_q;
  // Data needs one stage fewer: it lines up with the newer edge sample.
  logic [DATA_WIDTH-1:0]  data_q [SYNC_STAGES-1];

  // Shift the line and its companion data through the synchroniser stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
      // NOTE: arrays are not cleared by a single '0; each entry is reset so no
      // phantom edge or stale data appears after reset release.
      for (int i = 0; i < SYNC_STAGES-1; i++) data_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value, which is what makes this a shift chain.
      line_q    <= {line_q[SYNC_STAGES-2:0], line_i};
      data_q[0] <= data_i;
      for (int i = 1; i < SYNC_STAGES-1; i++) data_q[i] <= data_q[i-1];
    end
  end

  assign level_o = line_q[SYNC_STAGES-1];
  assign rise_o  =  line_q[SYNC_STAGES-2] & ~line_q[SYNC_STAGES-1];
  assign fall_o  = ~line_q[SYNC_STAGES-2] &  line_q[SYNC_STAGES-1];
  assign data_o  = data_q[SYNC_STAGES-2];

endmodule

// File: rtl/external_io_chain.sv
// Host IO block for the shapool miner: loads job/device config over two shift
// ports, runs the core, captures a result frame and shifts it down the chain.
module external_io_chain
  import external_io_pkg::*;
#(
  parameter int JOB_CONFIG_WIDTH    = 352,
  parameter int DEVICE_CONFIG_WIDTH = 8,
  parameter int RESULT_DATA_WIDTH   = 32,
  parameter int SYNC_STAGES         = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           sck0,
  input  logic                           sdi0,
  input  logic                           cs0_n,
  input  logic                           sck1,
  input  logic                           sdi1,
  output logic                           sdo1,
  input  logic                           cs1_n,
  input  logic                           start,
  input  logic                           ready_in,
  output logic                           ready_out,
  output logic                           shapool_run,
  output logic [JOB_CONFIG_WIDTH-1:0]    job_config,
  output logic [DEVICE_CONFIG_WIDTH-1:0] device_config,
  input  logic [RESULT_DATA_WIDTH-1:0]   shapool_result,
  input  logic                           shapool_success
);

  localparam int FW = frame_width(RESULT_DATA_WIDTH);

  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Reset asserts immediately and releases on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic sck0_rise, sdi0_s, cs0_n_s;
  logic sck1_rise, sck1_fall, sdi1_s, cs1_n_s;
  logic start_s, start_rise, ready_s;
  logic sck0_level_unused, sck0_fall_unused, sck1_level_unused;
  logic start_fall_unused, start_data_unused;
  logic ready_rise_unused, ready_fall_unused, ready_data_unused;

  io_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .DATA_WIDTH(2)) u_sync_port0 (
    .clk(clk), .rst_n(rst_n), .line_i(sck0), .data_i({sdi0, cs0_n}),
    .level_o(sck0_level_unused), .rise_o(sck0_rise), .fall_o(sck0_fall_unused),
    .data_o({sdi0_s, cs0_n_s})
  );

  io_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .DATA_WIDTH(2)) u_sync_port1 (
    .clk(clk), .rst_n(rst_n), .line_i(sck1), .data_i({sdi1, cs1_n}),
    .level_o(sck1_level_unused), .rise_o(sck1_rise), .fall_o(sck1_fall),
    .data_o({sdi1_s, cs1_n_s})
  );

  io_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .DATA_WIDTH(1)) u_sync_start (
    .clk(clk), .rst_n(rst_n), .line_i(start), .data_i(1'b0),
    .level_o(start_s), .rise_o(start_rise), .fall_o(start_fall_unused),
    .data_o(start_data_unused)
  );

  io_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .DATA_WIDTH(1)) u_sync_ready (
    .clk(clk), .rst_n(rst_n), .line_i(ready_in), .data_i(1'b0),
    .level_o(ready_s), .rise_o(ready_rise_unused), .fall_o(ready_fall_unused),
    .data_o(ready_data_unused)
  );

  state_e                         state_q, state_d;
  logic [JOB_CONFIG_WIDTH-1:0]    job_q, job_d;
  logic [DEVICE_CONFIG_WIDTH-1:0] dev_q, dev_d;
  logic [FW-1:0]                  frame_q, frame_d;
  logic                           sdo1_q, sdo1_d;
  logic                           ready_out_q, ready_out_d;

  logic shift0, shift1, out1;
  assign shift0 = sck0_rise & ~cs0_n_s;
  assign shift1 = sck1_rise & ~cs1_n_s;
  assign out1   = sck1_fall & ~cs1_n_s;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= STATE_LOAD;
      job_q       <= '0;
      dev_q       <= '0;
      frame_q     <= '0;
      sdo1_q      <= 1'b0;
      ready_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      job_q       <= job_d;
      dev_q       <= dev_d;
      frame_q     <= frame_d;
      sdo1_q      <= sdo1_d;
      ready_out_q <= ready_out_d;
    end
  end

  // Next-state logic: config load, run control, result capture and shift-out.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned,
    // which would infer a latch.
    state_d     = state_q;
    job_d       = job_q;
    dev_d       = dev_q;
    frame_d     = frame_q;
    sdo1_d      = sdo1_q;
    ready_out_d = (state_q == STATE_DONE) | ready_s;
    case (state_q)
      STATE_LOAD: begin
        if (shift0) job_d  = {job_q[JOB_CONFIG_WIDTH-2:0], sdi0_s};
        if (shift1) dev_d  = {dev_q[DEVICE_CONFIG_WIDTH-2:0], sdi1_s};
        if (out1)   sdo1_d = dev_q[DEVICE_CONFIG_WIDTH-1];
        if (start_rise && cs0_n_s && cs1_n_s) state_d = STATE_EXEC;
      end
      STATE_EXEC: begin
        // A found result outranks a stop request arriving in the same cycle.
        if (shapool_success) begin
          frame_d = {1'b1, shapool_result};
          sdo1_d  = 1'b1;
          state_d = STATE_DONE;
        end else if (ready_s || !cs1_n_s) begin
          frame_d = '0;
          sdo1_d  = 1'b0;
          state_d = STATE_DONE;
        end
      end
      STATE_DONE: begin
        if (shift1) frame_d = {frame_q[FW-2:0], sdi1_s};
        if (out1)   sdo1_d  = frame_q[FW-1];
        if (!start_s && cs1_n_s) state_d = STATE_LOAD;
      end
      default: begin
        state_d     = STATE_LOAD;
        job_d       = '0;
        dev_d       = '0;
        frame_d     = '0;
        sdo1_d      = 1'b0;
        ready_out_d = 1'b0;
      end
    endcase
  end

  assign job_config    = job_q;
  assign device_config = dev_q;
  assign sdo1          = sdo1_q;
  assign ready_out     = ready_out_q;
  assign shapool_run   = (state_q == STATE_EXEC);

endmodule

// File: tb/tb_external_io_chain.sv
// Bench for external_io_chain: two devices chained A -> B on the shift port,
// B's ready_in fed from A's ready_out. Result bits go through a scoreboard.
module tb_external_io_chain;

  localparam int JW    = 352;
  localparam int DW    = 8;
  localparam int RW    = 32;
  localparam int SS    = 2;
  localparam int FW    = RW + 1;
  localparam int HALF  = 8;
  localparam int HALF0 = 4;

  logic          clk, reset_n;
  logic          sck0, sdi0, cs0_n, sck1, sdi1_h, cs1_n, start, ready_a_in;
  logic          sdo1_a, ready_out_a, run_a, success_a;
  logic          sdo1_b, ready_out_b, run_b, success_b;
  logic [JW-1:0] job_a, job_b;
  logic [DW-1:0] dev_a, dev_b;
  logic [RW-1:0] result_a, result_b;

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];

  external_io_chain #(.JOB_CONFIG_WIDTH(JW), .DEVICE_CONFIG_WIDTH(DW),
                      .RESULT_DATA_WIDTH(RW), .SYNC_STAGES(SS)) u_dev_a (
    .clk(clk), .reset_n(reset_n), .sck0(sck0), .sdi0(sdi0), .cs0_n(cs0_n),
    .sck1(sck1), .sdi1(sdi1_h), .sdo1(sdo1_a), .cs1_n(cs1_n), .start(start),
    .ready_in(ready_a_in), .ready_out(ready_out_a), .shapool_run(run_a),
    .job_config(job_a), .device_config(dev_a), .shapool_result(result_a),
    .shapool_success(success_a)
  );

  external_io_chain #(.JOB_CONFIG_WIDTH(JW), .DEVICE_CONFIG_WIDTH(DW),
                      .RESULT_DATA_WIDTH(RW), .SYNC_STAGES(SS)) u_dev_b (
    .clk(clk), .reset_n(reset_n), .sck0(sck0), .sdi0(sdi0), .cs0_n(cs0_n),
    .sck1(sck1), .sdi1(sdo1_a), .sdo1(sdo1_b), .cs1_n(cs1_n), .start(start),
    .ready_in(ready_out_a), .ready_out(ready_out_b), .shapool_run(run_b),
    .job_config(job_b), .device_config(dev_b), .shapool_result(result_b),
    .shapool_success(success_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [FW-1:0] f);
    for (int i = FW-1; i >= 0; i--) exp_q.push_back(f[i]);
  endtask

  // Clock nbits out of A or B; sdo is sampled just before each rising sck.
  task automatic readout(input bit from_b, input int nbits, input logic din,
                         input string name);
    logic got, exp;
    cs1_n = 1'b0; sdi1_h = din; tick(HALF);
    for (int i = 0; i < nbits; i++) begin
      got = from_b ? sdo1_b : sdo1_a;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s bit %0d: got %b, scoreboard empty", name, i, got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL %s bit %0d: got %b expected %b", name, i, got, exp);
        end
      end
      sck1 = 1'b1; tick(HALF);
      sck1 = 1'b0; tick(HALF);
    end
    cs1_n = 1'b1; tick(HALF);
  endtask

  task automatic start_run(input string name);
    int n = 0;
    start = 1'b1;
    while (run_a !== 1'b1 && n < 20) begin tick(1); n++; end
    checks++;
    if (run_a !== 1'b1) begin
      errors++;
      $display("FAIL %s run_a: got %b expected 1 within 20 cycles", name, run_a);
    end
  endtask

  task automatic finish_run(input string name);
    start = 1'b0; tick(12);
    checks++;
    if ({ready_out_a, ready_out_b, run_a} !== 3'b000) begin
      errors++;
      $display("FAIL %s back to load {rdyA,rdyB,runA}: got %b expected 000",
               name, {ready_out_a, ready_out_b, run_a});
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sck0 = 0; sdi0 = 0; cs0_n = 1; sck1 = 0; sdi1_h = 0;
    cs1_n = 1; start = 0; ready_a_in = 0; success_a = 0; success_b = 0;
    result_a = '0; result_b = '0;
    tick(3);
    checks++;
    if ({run_a, ready_out_a, sdo1_a} !== 3'b000) begin
      errors++;
      $display("FAIL reset outputs {run,rdy,sdo1}: got %b expected 000",
               {run_a, ready_out_a, sdo1_a});
    end
    checks++;
    if (job_a !== '0 || dev_a !== '0) begin
      errors++;
      $display("FAIL reset configs: job lsbs %h dev %h expected 0", job_a[31:0], dev_a);
    end
    reset_n = 1'b1; tick(4);
  endtask

  task automatic test_job_load(input logic [JW-1:0] pat);
    cs0_n = 1'b0; tick(HALF0);
    for (int i = 0; i < JW; i++) begin
      sdi0 = pat[JW-1-i]; tick(HALF0);
      sck0 = 1'b1; tick(HALF0);
      sck0 = 1'b0;
    end
    tick(HALF0); cs0_n = 1'b1; tick(HALF0);
    checks++;
    if (job_a !== pat) begin
      errors++;
      $display("FAIL job_load: got lsbs %h expected %h", job_a[63:0], pat[63:0]);
    end
    checks++;
    if (dev_a !== '0) begin
      errors++;
      $display("FAIL job_load device_config: got %h expected 00", dev_a);
    end
  endtask

  // 16 bits through A into B: B keeps the first byte, A the second.
  task automatic test_dev_chain();
    logic [15:0] stream;
    stream = 16'h3C96;
    cs1_n = 1'b0; tick(HALF);
    for (int i = 0; i < 16; i++) begin
      sdi1_h = stream[15-i]; tick(HALF);
      sck1 = 1'b1; tick(HALF);
      sck1 = 1'b0;
    end
    tick(HALF); cs1_n = 1'b1; tick(HALF);
    checks++;
    if (dev_a !== 8'h96) begin
      errors++; $display("FAIL dev_chain A: got %h expected 96", dev_a);
    end
    checks++;
    if (dev_b !== 8'h3C) begin
      errors++; $display("FAIL dev_chain B: got %h expected 3c", dev_b);
    end
  endtask

  task automatic test_run_success();
    start_run("success");
    result_a = 32'h12345678; success_a = 1'b1;
    checks++;
    if (run_a !== 1'b1) begin
      errors++; $display("FAIL success run before pulse: got %b expected 1", run_a);
    end
    tick(1); success_a = 1'b0;
    checks++;
    if ({run_a, ready_out_a, sdo1_a} !== 3'b001) begin
      errors++;
      $display("FAIL success +1 {run,rdy,sdo1}: got %b expected 001",
               {run_a, ready_out_a, sdo1_a});
    end
    tick(1);
    checks++;
    if (ready_out_a !== 1'b1) begin
      errors++; $display("FAIL success +2 ready_out: got %b expected 1", ready_out_a);
    end
    push_frame({1'b1, 32'h12345678});
    readout(1'b0, FW, 1'b1, "success_frame");
    finish_run("success");
  endtask

  task automatic test_neighbour_stop();
    start_run("neighbour");
    ready_a_in = 1'b1; tick(SS);
    checks++;
    if (run_a !== 1'b1) begin
      errors++; $display("FAIL neighbour early stop: run got %b expected 1", run_a);
    end
    tick(1);
    checks++;
    if ({run_a, ready_out_a, sdo1_a} !== 3'b010) begin
      errors++;
      $display("FAIL neighbour stop {run,rdy,sdo1}: got %b expected 010",
               {run_a, ready_out_a, sdo1_a});
    end
    ready_a_in = 1'b0;
    push_frame('0);
    readout(1'b0, FW, 1'b1, "neighbour_frame");
    finish_run("neighbour");
  endtask

  task automatic test_priority();
    start_run("priority");
    ready_a_in = 1'b1; tick(SS);
    result_a = 32'h0F0FA5C3; success_a = 1'b1;
    tick(1); success_a = 1'b0; ready_a_in = 1'b0;
    checks++;
    if ({run_a, sdo1_a} !== 2'b01) begin
      errors++;
      $display("FAIL priority {run,sdo1}: got %b expected 01", {run_a, sdo1_a});
    end
    push_frame({1'b1, 32'h0F0FA5C3});
    readout(1'b0, FW, 1'b0, "priority_frame");
    finish_run("priority");
  endtask

  task automatic test_two_device();
    start_run("chain");
    checks++;
    if (run_b !== 1'b1) begin
      errors++; $display("FAIL chain B run: got %b expected 1", run_b);
    end
    result_a = 32'hDEADBEEF; success_a = 1'b1;
    tick(1); success_a = 1'b0;
    tick(1);
    checks++;
    if ({ready_out_a, ready_out_b} !== 2'b10) begin
      errors++;
      $display("FAIL chain ready {A,B}: got %b expected 10", {ready_out_a, ready_out_b});
    end
    tick(SS);
    checks++;
    if ({ready_out_b, run_b} !== 2'b01) begin
      errors++;
      $display("FAIL chain B before stop {rdy,run}: got %b expected 01", {ready_out_b, run_b});
    end
    tick(1);
    checks++;
    if ({ready_out_b, run_b} !== 2'b10) begin
      errors++;
      $display("FAIL chain B stopped {rdy,run}: got %b expected 10", {ready_out_b, run_b});
    end
    push_frame('0);
    push_frame({1'b1, 32'hDEADBEEF});
    readout(1'b1, 2*FW, 1'b0, "chain_frames");
    finish_run("chain");
  endtask

  task automatic test_reset_mid_shift(input logic [JW-1:0] pat);
    logic [7:0] cfg;
    cfg = 8'hA1;
    cs0_n = 1'b0; cs1_n = 1'b0; tick(HALF);
    for (int i = 0; i < 100; i++) begin
      sdi0 = pat[JW-1-i];
      if (i < 8) sdi1_h = cfg[7-i];
      tick(HALF);
      sck0 = 1'b1;
      if (i < 8) sck1 = 1'b1;
      tick(HALF);
      sck0 = 1'b0; sck1 = 1'b0;
    end
    tick(HALF);
    checks++;
    if (job_a[99:0] !== pat[JW-1 -: 100] || dev_a !== cfg || sdo1_a !== 1'b1) begin
      errors++;
      $display("FAIL dual_port shift: job lsbs %h dev %h sdo1 %b expected %h %h 1",
               job_a[99:0], dev_a, sdo1_a, pat[JW-1 -: 100], cfg);
    end
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (job_a !== '0 || dev_a !== '0 || {sdo1_a, run_a, ready_out_a} !== 3'b000) begin
      errors++;
      $display("FAIL async reset: job lsbs %h dev %h {sdo1,run,rdy} %b expected 0 0 000",
               job_a[31:0], dev_a, {sdo1_a, run_a, ready_out_a});
    end
    cs0_n = 1'b1; cs1_n = 1'b1; start = 1'b0;
    tick(2); reset_n = 1'b1; tick(4);
    start_run("after_reset");
    start = 1'b0; tick(4);
  endtask

  initial begin
    logic [JW-1:0] pat;
    pat = {(JW/8){8'hA5}};
    test_reset();
    test_job_load(pat);
    test_dev_chain();
    test_run_success();
    test_neighbour_stop();
    test_priority();
    test_two_device();
    test_reset_mid_shift(pat);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
